mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the core's data-memory store port, in parallel with DMEM.

---
 rtl/mmio_uart_tx.sv | 140 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the data-memory store port.
// Stores to TX_ADDR queue bytes in a FIFO; the status word is readable at STAT_ADDR.
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_0400,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_0404,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        tx,
    output logic        tx_busy,
    output logic        fifo_full
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    state_t        state_q;
    logic [KW-1:0] clk_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q, busy_q;

    logic push_req, push, pop, clr, fifo_empty, bit_done;
    logic wdata_unused;

    assign push_req   = mem_write && (addr == TX_ADDR);
    assign clr        = mem_write && (addr == STAT_ADDR) && w_data[0];
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = push_req && !fifo_full;
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign bit_done   = (clk_cnt_q == KW'(CLKS_PER_BIT - 1));
    assign wdata_unused = ^w_data[31:8];

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign r_data  = (addr == STAT_ADDR) ?
                     {16'b0, 8'(count_q), 4'b0, ovf_q, busy_q, fifo_empty, fifo_full} :
                     32'b0;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (push_req && fifo_full) ovf_d = 1'b1;
        // A clear in the same cycle as a dropped push leaves the flag clear
        if (clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= w_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        state_q   <= START;
                        clk_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        clk_cnt_q <= clk_cnt_q + KW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + KW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + KW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-timing model checked every cycle,
// plus directed scenarios pinned by hand-computed literals.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] TXA   = 32'h0000_0400;
    localparam logic [31:0] STA   = 32'h0000_0404;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] w_data = '0;
    logic [31:0] r_data;
    logic        tx, tx_busy, fifo_full;

    int ncmp = 0;
    int nbad = 0;
    bit chk_en = 0;

    mmio_uart_tx #(.TX_ADDR(TXA), .STAT_ADDR(STA),
                   .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write),
        .addr(addr), .w_data(w_data), .r_data(r_data),
        .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the position within the current frame
    logic [7:0] mq[$];
    logic [7:0] cur = '0;
    bit         mbusy = 0;
    bit         movf = 0;
    int         cyc = 0;

    function automatic logic exp_tx();
        int k;
        if (!mbusy) return 1'b1;
        k = cyc / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [7:0] n;
        if (addr != STA) return 32'b0;
        n = 8'(mq.size());
        return {16'b0, n, 4'b0, movf, mbusy, mq.size() == 0, mq.size() == DEPTH};
    endfunction

    initial forever begin
        int  n0;
        bit  pw, cl;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            mbusy = 0;
            movf = 0;
            cyc = 0;
        end else begin
            n0 = mq.size();
            pw = mem_write && addr == TXA;
            cl = mem_write && addr == STA && w_data[0];
            if (mbusy) begin
                cyc++;
                if (cyc == 10 * CPB) mbusy = 0;
            end else if (n0 > 0) begin
                cur = mq.pop_front();
                mbusy = 1;
                cyc = 0;
            end
            if (pw) begin
                if (n0 < DEPTH) mq.push_back(w_data[7:0]);
                else movf = 1;
            end
            if (cl) movf = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_tx", tx, exp_tx());
            chk("cyc_busy", tx_busy, mbusy);
            chk("cyc_full", fifo_full, mq.size() == DEPTH);
            chk("cyc_rdata", r_data, exp_rd());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        addr = a;
        w_data = d;
        tick();
        mem_write = 1'b0;
        addr = '0;
        w_data = '0;
    endtask

    task automatic rd(output logic [31:0] v);
        addr = STA;
        #1;
        v = r_data;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        addr = STA;
        #1;
        for (int i = 0; i < 3000; i++) begin
            if (!tx_busy && r_data[1]) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("drain_done", 32'(ok), 32'd1);
    endtask

    logic [31:0] v;
    logic [9:0]  pat;
    int          busy_n, noisy;

    initial begin
        // T1 reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1;
        chk("t1_tx", tx, 1'b1);
        chk("t1_busy", tx_busy, 1'b0);
        chk("t1_full", fifo_full, 1'b0);
        rd(v);
        chk("t1_stat", v, 32'h0000_0002);
        tick();

        // T2 single frame 0xA5
        pat = {1'b1, 8'hA5, 1'b0};
        store(TXA, 32'h1234_56A5);
        chk("t2_pre", tx, 1'b1);
        tick();
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            chk("t2_tx", tx, pat[i/4]);
            busy_n += int'(tx_busy);
            tick();
        end
        chk("t2_busy_len", busy_n, 40);
        chk("t2_end_busy", tx_busy, 1'b0);
        chk("t2_end_tx", tx, 1'b1);

        // T3 fill past full
        for (int k = 1; k <= 9; k++) store(TXA, 32'(k));
        rd(v);
        chk("t3_stat9", v, 32'h0000_0805);
        store(TXA, 32'h0A);
        rd(v);
        chk("t3_stat10", v, 32'h0000_080D);

        // T4 overflow clear
        store(STA, 32'h0);
        rd(v);
        chk("t4_noclr", v & 32'h8, 32'h8);
        store(STA, 32'h1);
        rd(v);
        chk("t4_clr", v & 32'h8, 32'h0);
        store(STA, 32'h0);
        rd(v);
        chk("t4_stay", v & 32'h8, 32'h0);
        wait_idle();
        tick();

        // T5 reset during data bit 3
        store(TXA, 32'h3C);
        store(TXA, 32'hC3);
        for (int i = 0; i < 17; i++) tick();
        chk("t5_bit3", tx, 1'b1);
        chk("t5_busy", tx_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_tx", tx, 1'b1);
        chk("t5_idle", tx_busy, 1'b0);
        rd(v);
        chk("t5_stat", v, 32'h0000_0002);
        noisy = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!tx || tx_busy) noisy++;
        end
        chk("t5_quiet", noisy, 0);

        // T6 ignored stores
        store(32'h0000_0408, 32'hFF);
        mem_write = 1'b0;
        addr = TXA;
        w_data = 32'hFF;
        tick();
        rd(v);
        chk("t6_stat", v, 32'h0000_0002);
        noisy = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!tx || tx_busy) noisy++;
        end
        chk("t6_quiet", noisy, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
